// File: rtl/dot_board_ctrl.sv
// Live pellet board for the 12x12 maze: loads a level's start map from the dot ROM,
// counts its dots one row per cycle, then clears dots as they are eaten.
module dot_board_ctrl #(
    parameter int ROWS  = 12,
    parameter int COLS  = 12,
    parameter int CNT_W = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   load_req,
    input  logic [1:0]             load_level,
    output logic [1:0]             level_sel,
    input  logic [ROWS*COLS-1:0]   dot_start_map,
    input  logic                   eat_valid,
    input  logic [3:0]             eat_row,
    input  logic [3:0]             eat_col,
    input  logic [3:0]             rd_row,
    input  logic [3:0]             rd_col,
    output logic                   rd_dot,
    output logic [CNT_W-1:0]       dots_left,
    output logic                   busy,
    output logic                   dot_eaten,
    output logic                   level_clear,
    output logic [2:0]             dbg_state
);

    localparam int MAP_W = ROWS * COLS;
    localparam int IDX_W = $clog2(MAP_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COUNT = 3'd2,
        S_PLAY  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MAP_W-1:0]   r_board;
    logic [1:0]         r_level_sel;
    logic [CNT_W-1:0]   r_dots_left;
    logic [CNT_W-1:0]   r_acc;
    logic [3:0]         r_row;
    logic               r_dot_eaten;

    logic [COLS-1:0]    w_row_bits;
    logic [CNT_W-1:0]   w_total;
    logic               w_last_row;
    logic [IDX_W-1:0]   w_eat_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_eat_in;
    logic               w_rd_in;
    logic               w_eat_hit;

    // Row 0 occupies the top bits; column 0 is the MSB of each row.
    function automatic logic [IDX_W-1:0] bit_idx(input logic [3:0] r, input logic [3:0] c);
        return IDX_W'(MAP_W - 1) - (IDX_W'(COLS) * IDX_W'(r) + IDX_W'(c));
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [COLS-1:0] b);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < COLS; i++)
            s = s + CNT_W'(b[i]);
        return s;
    endfunction

    always_comb begin
        w_row_bits = '0;
        for (int c = 0; c < COLS; c++)
            w_row_bits[COLS-1-c] = r_board[bit_idx(r_row, 4'(c))];
    end

    assign w_total    = r_acc + popcnt(w_row_bits);
    assign w_last_row = (r_row == 4'(ROWS - 1));
    assign w_eat_idx  = bit_idx(eat_row, eat_col);
    assign w_rd_idx   = bit_idx(rd_row, rd_col);
    assign w_eat_in   = (eat_row < 4'(ROWS)) && (eat_col < 4'(COLS));
    assign w_rd_in    = (rd_row < 4'(ROWS)) && (rd_col < 4'(COLS));

    // A reload on the same edge always wins over an eat.
    assign w_eat_hit  = (r_state == S_PLAY) && eat_valid && w_eat_in && !load_req &&
                        r_board[w_eat_idx] && (r_dots_left != '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  w_state_nxt = S_COUNT;
            S_COUNT: if (w_last_row) w_state_nxt = (w_total != '0) ? S_PLAY : S_CLEAR;
            S_PLAY:  if (w_eat_hit && (r_dots_left == CNT_W'(1))) w_state_nxt = S_CLEAR;
            default: ;
        endcase
        if (load_req) w_state_nxt = S_LOAD;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_board     <= '0;
            r_level_sel <= '0;
            r_dots_left <= '0;
            r_acc       <= '0;
            r_row       <= '0;
            r_dot_eaten <= 1'b0;
        end else begin
            r_dot_eaten <= w_eat_hit;
            if (load_req) begin
                r_level_sel <= load_level;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_board <= dot_start_map;
                        r_acc   <= '0;
                        r_row   <= '0;
                    end
                    S_COUNT: begin
                        if (w_last_row) begin
                            r_dots_left <= w_total;
                            r_row       <= '0;
                        end else begin
                            r_acc <= w_total;
                            r_row <= r_row + 4'd1;
                        end
                    end
                    S_PLAY: begin
                        if (w_eat_hit) begin
                            r_board[w_eat_idx] <= 1'b0;
                            r_dots_left        <= r_dots_left - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign level_sel   = r_level_sel;
    assign rd_dot      = w_rd_in ? r_board[w_rd_idx] : 1'b0;
    assign dots_left   = r_dots_left;
    assign busy        = (r_state == S_LOAD) || (r_state == S_COUNT);
    assign dot_eaten   = r_dot_eaten;
    assign level_clear = (r_state == S_CLEAR);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_dot_board_ctrl.sv
// Bench for dot_board_ctrl: a level-map ROM stand-in plus a tile-array reference model
// stepped once per clock, covering directed scenarios and a random phase.
module tb_dot_board_ctrl;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         load_req;
  logic [1:0]   load_level;
  logic [1:0]   level_sel;
  logic [143:0] dot_start_map;
  logic         eat_valid;
  logic [3:0]   eat_row;
  logic [3:0]   eat_col;
  logic [3:0]   rd_row;
  logic [3:0]   rd_col;
  logic         rd_dot;
  logic [7:0]   dots_left;
  logic         busy;
  logic         dot_eaten;
  logic         level_clear;
  logic [2:0]   dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  bit         m_board[12][12];
  int         m_dots;
  int         m_cd;
  bit         m_play;
  bit         m_clear;
  bit         m_pulse;
  logic [1:0] m_sel;

  dot_board_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .load_req(load_req), .load_level(load_level),
    .level_sel(level_sel), .dot_start_map(dot_start_map), .eat_valid(eat_valid),
    .eat_row(eat_row), .eat_col(eat_col), .rd_row(rd_row), .rd_col(rd_col),
    .rd_dot(rd_dot), .dots_left(dots_left), .busy(busy), .dot_eaten(dot_eaten),
    .level_clear(level_clear), .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  // level 0/3: row 4 full (12); level 1: 10x10 interior (100);
  // level 2: all but rows 0, 11 and (5,0..3) (116)
  function automatic bit tile(input logic [1:0] lvl, input int r, input int c);
    case (lvl)
      2'd1:    return (r >= 1 && r <= 10 && c >= 1 && c <= 10);
      2'd2:    return !(r == 0 || r == 11 || (r == 5 && c < 4));
      default: return (r == 4);
    endcase
  endfunction

  function automatic logic [143:0] rom_map(input logic [1:0] lvl);
    logic [143:0] m;
    m = '0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++)
        m[143 - (12 * r + c)] = tile(lvl, r, c);
    return m;
  endfunction

  always_comb dot_start_map = rom_map(level_sel);

  function automatic bit board_at(input logic [3:0] r, input logic [3:0] c);
    if (r >= 12 || c >= 12) return 1'b0;
    return m_board[r][c];
  endfunction

  function automatic int board_count();
    int n;
    n = 0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++)
        n += int'(m_board[r][c]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++)
        m_board[r][c] = 1'b0;
    m_dots = 0; m_cd = 0; m_play = 0; m_clear = 0; m_pulse = 0; m_sel = 2'd0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".busy"}, 32'(busy), 32'(m_cd > 0));
    chk({where, ".dot_eaten"}, 32'(dot_eaten), 32'(m_pulse));
    chk({where, ".level_clear"}, 32'(level_clear), 32'(m_clear));
    chk({where, ".level_sel"}, 32'(level_sel), 32'(m_sel));
    if (m_cd == 0) chk({where, ".dots_left"}, 32'(dots_left), 32'(m_dots));
    chk({where, ".rd_dot"}, 32'(rd_dot), 32'(board_at(rd_row, rd_col)));
  endtask

  // One clock: drive at negedge, advance model at posedge, check 1ns later.
  task automatic step(input bit ld, input logic [1:0] lvl, input bit ev,
                      input logic [3:0] er, input logic [3:0] ec);
    bit hit;
    @(negedge Clk);
    load_req = ld; load_level = lvl; eat_valid = ev; eat_row = er; eat_col = ec;
    rd_row = 4'($urandom_range(13, 0));
    rd_col = 4'($urandom_range(13, 0));
    @(posedge Clk);
    hit = !ld && m_cd == 0 && m_play && ev && board_at(er, ec);
    m_pulse = hit;
    if (ld) begin
      m_sel = lvl; m_cd = 13; m_play = 0; m_clear = 0;
    end else if (m_cd > 0) begin
      if (m_cd == 13)
        for (int r = 0; r < 12; r++)
          for (int c = 0; c < 12; c++)
            m_board[r][c] = tile(m_sel, r, c);
      m_cd--;
      if (m_cd == 0) begin
        m_dots = board_count(); m_play = (m_dots != 0); m_clear = (m_dots == 0);
      end
    end else if (hit) begin
      m_board[er][ec] = 1'b0;
      m_dots--;
      if (m_dots == 0) begin m_play = 0; m_clear = 1; end
    end
    #1;
    check_outputs("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic rd_chk(input logic [3:0] r, input logic [3:0] c);
    rd_row = r; rd_col = c;
    #1;
    chk("rd_dot_directed", 32'(rd_dot), 32'(board_at(r, c)));
  endtask

  task automatic check_reset_vals();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.dot_eaten", 32'(dot_eaten), 32'd0);
    chk("rst.level_clear", 32'(level_clear), 32'd0);
    chk("rst.level_sel", 32'(level_sel), 32'd0);
    chk("rst.dots_left", 32'(dots_left), 32'd0);
    for (int i = 0; i < 6; i++) begin
      rd_row = 4'(2 * i); rd_col = 4'(11 - 2 * i);
      #1;
      chk("rst.rd_dot", 32'(rd_dot), 32'd0);
    end
    rd_row = 4'd4; rd_col = 4'd4;
    #1;
    chk("rst.rd_dot44", 32'(rd_dot), 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0; load_req = 0; load_level = 0; eat_valid = 0;
    eat_row = 0; eat_col = 0; rd_row = 0; rd_col = 0;
    model_reset();
    #2;
    check_reset_vals();
    @(negedge Clk);
    Reset_n = 1'b1;
    idle(2);

    // level 0 load and basic reads
    step(1'b1, 2'd0, 1'b0, 4'd0, 4'd0);
    idle(13);
    chk("lvl0.dots", 32'(dots_left), 32'd12);
    rd_chk(4'd4, 4'd4); rd_chk(4'd5, 4'd5); rd_chk(4'd0, 4'd0);

    // the other levels
    for (int l = 1; l < 4; l++) begin
      step(1'b1, 2'(l), 1'b0, 4'd0, 4'd0);
      idle(13);
      rd_chk(4'd1, 4'd0);
    end

    // level 0 eating, holding, and ignored eats
    step(1'b1, 2'd0, 1'b0, 4'd0, 4'd0);
    idle(13);
    step(1'b0, 2'd0, 1'b1, 4'd4, 4'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b1, 4'd4, 4'd4);
    step(1'b0, 2'd0, 1'b1, 4'd0, 4'd0);
    step(1'b0, 2'd0, 1'b1, 4'd12, 4'd3);
    chk("eat.dots11", 32'(dots_left), 32'd11);

    // eat the rest of row 4 -> clear, then ignored eats, then reload
    for (int c = 0; c < 12; c++)
      if (c != 4) step(1'b0, 2'd0, 1'b1, 4'd4, 4'(c));
    step(1'b0, 2'd0, 1'b1, 4'd4, 4'd0);
    step(1'b0, 2'd0, 1'b1, 4'd4, 4'd7);
    step(1'b1, 2'd0, 1'b0, 4'd0, 4'd0);

    // restart mid-COUNT with another level, eats while busy
    idle(5);
    step(1'b1, 2'd2, 1'b1, 4'd4, 4'd4);
    for (int i = 0; i < 13; i++) step(1'b0, 2'd0, 1'b1, 4'd6, 4'(i % 12));
    chk("restart.dots", 32'(dots_left), 32'd116);

    // simultaneous load and valid eat in PLAY
    step(1'b1, 2'd0, 1'b1, 4'd6, 4'd6);
    idle(13);

    // asynchronous reset mid-COUNT
    step(1'b1, 2'd1, 1'b0, 4'd0, 4'd0);
    idle(5);
    #2;
    Reset_n = 1'b0;
    load_req = 1'b0; eat_valid = 1'b0;
    #1;
    model_reset();
    check_reset_vals();
    @(negedge Clk);
    Reset_n = 1'b1;
    idle(2);

    // random phase
    step(1'b1, 2'($urandom_range(3, 0)), 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 900; i++) begin
      bit ld;
      logic [3:0] er;
      ld = ($urandom_range(39, 0) == 0);
      er = ($urandom_range(1, 0) == 1) ? 4'd4 : 4'($urandom_range(13, 0));
      step(ld, 2'($urandom_range(3, 0)), ($urandom_range(3, 0) != 0),
           er, 4'($urandom_range(13, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_board_ctrl.md
Name: dot_board_ctrl

Overview:
- Owns live pellet state for the 12x12 maze.
- On a level-load request it selects the level in the dot-start ROM, captures the 144-bit start map into a board register, and counts the dots row by row.
- During play it clears dots as Pac-Man eats them, emits score pulses, and flags level-clear when the count reaches zero.
- Sits between the game FSM (load/eat requests), the dot-start ROM (level select / map), and the renderer (read port).

Parameters:
- ROWS, 12, maze rows (fixed; map width = ROWS*COLS).
- COLS, 12, maze columns (fixed).
- CNT_W, 8, width of the dot counter (max 144).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- load_req  in  1  one-cycle pulse: start loading level `load_level`
- load_level  in  2  level to load (0 default, 1, 2; 3 behaves as default in ROM)
- level_sel  out  2  registered level select driven to the dot-start ROM
- dot_start_map  in  144  start map from ROM; bits [143:132] are row 0, MSB of each row is column 0
- eat_valid  in  1  Pac-Man occupies tile (eat_row, eat_col) this cycle
- eat_row  in  4  tile row
- eat_col  in  4  tile column
- rd_row  in  4  renderer query row
- rd_col  in  4  renderer query column
- rd_dot  out  1  combinational: dot present at (rd_row, rd_col); 0 if out of range
- dots_left  out  CNT_W  remaining dots (valid in PLAY/CLEAR)
- busy  out  1  high in LOAD and COUNT
- dot_eaten  out  1  registered one-cycle pulse per dot consumed
- level_clear  out  1  high while in CLEAR

Behaviour:
- Bit index for (r,c) = 143 - (12*r + c).
- Reset values: state IDLE; board all 0; level_sel 0; dots_left 0; row index 0; accumulator 0; busy, dot_eaten, level_clear all 0.
- States: IDLE, LOAD, COUNT, PLAY, CLEAR.
- load_req is accepted in every state, including mid-COUNT and PLAY, and restarts the sequence.
  - Edge t (load_req high): level_sel <= load_level; state -> LOAD.
  - LOAD: ROM settles a full cycle. Edge t+1: board <= dot_start_map; acc <= 0; row <= 0; state -> COUNT.
  - COUNT: each edge adds popcount of board row `row` to acc and increments row.
  - At the edge processing row 11 (edge t+13): dots_left <= acc + popcount(row 11); row <= 0.
  - Then state -> PLAY if that total is nonzero, otherwise CLEAR.
  - busy is high for exactly 13 cycles (LOAD + 12 COUNT).
- Eat handling applies in PLAY only. It requires eat_valid=1, eat_row<12, eat_col<12, and board bit = 1. On that edge:
  - bit cleared;
  - dots_left decremented;
  - dot_eaten = 1 for the following cycle;
  - if dots_left was 1, state -> CLEAR.
- Eats are ignored, with no pulse and no change, in IDLE, LOAD, COUNT and CLEAR. They are also ignored on already-empty tiles and for out-of-range coordinates.
- Holding eat_valid on the same tile yields exactly one dot_eaten pulse.
- If load_req and a valid eat occur on the same edge, load wins and the eat is dropped.
- CLEAR: level_clear is held high and the board is frozen until load_req.
- dots_left never underflows; no decrement is possible at 0.
- rd_dot reads the current board register; a write on edge N is visible after edge N.
- Reset_n low at any time, including mid-COUNT, forces all reset values immediately.

Test Plan:
- Reset, then load_level=0 pulse: level_sel=0 after 1 edge, busy high for 13 cycles, then PLAY with dots_left=12. rd_dot(4,4)=1, rd_dot(5,5)=0, rd_dot(0,0)=0.
- Load level 1 -> dots_left=100. Load level 2 -> dots_left=116. Load level 3 -> dots_left=12. For each, rd_dot(1,0) is 0 / 1 / 0 respectively.
- Level 0 in PLAY: eat (4,4) -> one dot_eaten pulse, dots_left=11, rd_dot(4,4)=0. Holding eat_valid on (4,4) for 5 more cycles -> no pulses, dots_left stays 11. Eat (0,0) and (12,3) -> ignored.
- Level 0: eat all 12 dots -> dots_left=0, level_clear=1 on the cycle after the last eat. Further eats are ignored. load_req then drops level_clear, and busy rises.
- load_req issued mid-COUNT (cycle 6) with a different level -> sequence restarts; dots_left reflects the new level 13 cycles later. An eat during busy is ignored. Simultaneous load_req and valid eat in PLAY -> no dot_eaten, reload occurs.
- Assert Reset_n low mid-COUNT asynchronously -> outputs immediately at reset values. board is read as all-zero (rd_dot=0 everywhere), state IDLE.
